// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling, start-glitch rejection,
// framing-error detection with a BREAK hold until the line returns idle.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_rx_in,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_rx_frame_err,
    output logic                  o_rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rx_s_q, rx_s_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        sync1_d = i_rx_in;
        rx_s_d  = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d                       = '0;
                    shift_d[idx_q[IW-2:0]]      = rx_s_q;
                    idx_d                       = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_rx_data      = data_q;
        o_rx_valid     = valid_q;
        o_rx_frame_err = ferr_q;
        o_rx_busy      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast instance (4 clks/bit) for directed cases and a
// 16 clks/bit instance for a random loopback run.
module tb_uart_rx;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx4 = 1'b1, rx16 = 1'b1;
    logic [7:0] d4, d16;
    logic       v4, f4, b4, v16, f16, b16;

    exp_t q4[$];
    exp_t q16[$];
    logic [7:0] last4 = 8'h00, last16 = 8'h00;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(4), .DATA_WIDTH(8)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_in(rx4),
        .o_rx_data(d4), .o_rx_valid(v4), .o_rx_frame_err(f4), .o_rx_busy(b4)
    );

    uart_rx #(.CLKS_PER_BIT(16), .DATA_WIDTH(8)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_in(rx16),
        .o_rx_data(d16), .o_rx_valid(v16), .o_rx_frame_err(f16), .o_rx_busy(b16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic check_pulse(input string nm, input exp_t e, input logic v, input logic f,
                               input logic [7:0] d);
        $display("%s %s data=%02h (expected %s data=%02h)", nm, f ? "frame_err" : "valid", d,
                 e.ferr ? "frame_err" : "valid", e.data);
        chk({nm, " both_pulses"}, {31'd0, v & f}, 32'd0);
        chk({nm, " pulse_kind"}, {31'd0, f}, {31'd0, e.ferr});
        chk({nm, " data"}, {24'd0, d}, {24'd0, e.data});
    endtask

    // Monitor: every output pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (v4 || f4)) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4 unexpected pulse valid=%0b ferr=%0b data=%02h required=none", v4, f4, d4);
            end else check_pulse("dut4", q4.pop_front(), v4, f4, d4);
        end
        if (rst_n && (v16 || f16)) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut16 unexpected pulse valid=%0b ferr=%0b data=%02h required=none", v16, f16, d16);
            end else check_pulse("dut16", q16.pop_front(), v16, f16, d16);
        end
    end

    task automatic drive(input bit sel, input logic b, input int n);
        if (sel) rx16 = b; else rx4 = b;
        repeat (n) @(negedge clk);
    endtask

    // Reference: frame is start(0), 8 data bits LSB first, stop; good stop yields the word,
    // bad stop yields a framing error with the previous word still shown.
    task automatic send(input bit sel, input logic [7:0] data, input logic stop);
        int   cpb = sel ? 16 : 4;
        exp_t e;
        e.ferr = ~stop;
        if (stop) begin
            if (sel) last16 = data; else last4 = data;
        end
        e.data = sel ? last16 : last4;
        if (sel) q16.push_back(e); else q4.push_back(e);
        drive(sel, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive(sel, data[i], cpb);
        drive(sel, stop, cpb);
    endtask

    task automatic wait_drain(input bit sel, input int budget);
        int n = 0;
        while ((sel ? q16.size() : q4.size()) > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sel ? q16.size() : q4.size()) > 0) begin
            errors++;
            $display("FAIL %s drain_timeout pending=%0d required=0", sel ? "dut16" : "dut4",
                     sel ? q16.size() : q4.size());
            if (sel) q16.delete(); else q4.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        repeat (3) @(negedge clk);
        chk("reset data4", {24'd0, d4}, 32'd0);
        chk("reset valid4", {31'd0, v4}, 32'd0);
        chk("reset ferr4", {31'd0, f4}, 32'd0);
        chk("reset busy4", {31'd0, b4}, 32'd0);
        chk("reset data16", {24'd0, d16}, 32'd0);
        chk("reset busy16", {31'd0, b16}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single good frame
        send(1'b0, 8'hA5, 1'b1);
        wait_drain(1'b0, 12);
        repeat (4) @(negedge clk);
        chk("a5 data held", {24'd0, d4}, 32'hA5);
        chk("a5 busy low", {31'd0, b4}, 32'd0);

        // One-cycle glitch must be rejected as a false start
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 12);
        chk("glitch busy low", {31'd0, b4}, 32'd0);
        chk("glitch data kept", {24'd0, d4}, 32'hA5);

        // Good frame then a framing error with the line held low
        send(1'b0, 8'h3C, 1'b1);
        drive(1'b0, 1'b1, 4);
        send(1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 10);
            chk("break busy high", {31'd0, b4}, 32'd1);
        end
        wait_drain(1'b0, 4);
        chk("break data kept", {24'd0, d4}, 32'h3C);
        drive(1'b0, 1'b1, 5);
        chk("break busy released", {31'd0, b4}, 32'd0);

        // Back-to-back frames, single stop bit each
        send(1'b0, 8'h00, 1'b1);
        send(1'b0, 8'hFF, 1'b1);
        send(1'b0, 8'h81, 1'b1);
        wait_drain(1'b0, 12);
        drive(1'b0, 1'b1, 8);

        // Reset during data bit 3 of 0x5A discards the frame
        w = 8'h5A;
        drive(1'b0, 1'b0, 4);
        for (int i = 0; i < 3; i++) drive(1'b0, w[i], 4);
        drive(1'b0, w[3], 2);
        rst_n = 1'b0;
        last4 = 8'h00;
        last16 = 8'h00;
        @(negedge clk);
        chk("midreset busy", {31'd0, b4}, 32'd0);
        chk("midreset data", {24'd0, d4}, 32'd0);
        chk("midreset valid", {31'd0, v4}, 32'd0);
        drive(1'b0, 1'b1, 2);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 12);
        chk("post reset idle", {31'd0, b4}, 32'd0);
        send(1'b0, 8'h12, 1'b1);
        wait_drain(1'b0, 12);
        repeat (4) @(negedge clk);
        chk("after reset data", {24'd0, d4}, 32'h12);

        // Random loopback at 16 clocks per bit
        drive(1'b1, 1'b1, 20);
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b1, $urandom_range(1, 20));
        end
        wait_drain(1'b1, 48);
        drive(1'b1, 1'b1, 20);
        chk("loopback data final", {24'd0, d16}, {24'd0, last16});
        chk("loopback busy low", {31'd0, b16}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
